// File: rtl/Purple_Jade_pkg.sv
// Shared physical-register parameters for rename, ROB and the register file.
// NUM_ARCH_REG must match the register-file valid reset image (pregs 0..NUM_ARCH_REG-1 live at reset).
package Purple_Jade_pkg;

    localparam int NUM_PHYS_REG = 128;
    localparam int NUM_ARCH_REG = 16;
    localparam int PREG_W       = $clog2(NUM_PHYS_REG);

    typedef logic [PREG_W-1:0] preg_id_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register IDs: one allocation and one free per cycle,
// with flush rollback of speculative allocations to the committed head.
module phys_reg_free_list
    import Purple_Jade_pkg::*;
#(
    parameter int FL_DEPTH = NUM_PHYS_REG
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    output logic                         alloc_v_o,
    output preg_id_t                     alloc_preg_o,
    input  logic                         alloc_yumi_i,
    input  logic                         rob_phys_valid_i,
    input  preg_id_t                     rob_phys_reg_cl_i,
    input  logic                         rob_commit_alloc_i,
    input  logic                         flush_i,
    output logic [$clog2(FL_DEPTH):0]    free_count_o
);

    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int PTR_W    = IDX_W + 1;
    localparam int NUM_FREE = NUM_PHYS_REG - NUM_ARCH_REG;

    preg_id_t               ring_q [FL_DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       commit_head_q, commit_head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic                   alloc_v_q, alloc_v_d;
    preg_id_t               alloc_preg_q, alloc_preg_d;
    logic [PTR_W-1:0]       free_count_q, free_count_d;
    logic                   alloc_fire_s;

    // Next-state pointers and the registered view of the new head.
    always_comb begin
        alloc_fire_s  = alloc_v_q & alloc_yumi_i & ~flush_i;
        commit_head_d = commit_head_q + PTR_W'(rob_commit_alloc_i);
        tail_d        = tail_q + PTR_W'(rob_phys_valid_i);
        if (flush_i) begin
            head_d = commit_head_d;
        end else begin
            head_d = head_q + PTR_W'(alloc_fire_s);
        end
        alloc_v_d    = (head_d != tail_d);
        free_count_d = tail_d - head_d;
        // The slot being written this cycle can only alias the new head when the list was empty.
        if (rob_phys_valid_i && (tail_q[IDX_W-1:0] == head_d[IDX_W-1:0])) begin
            alloc_preg_d = rob_phys_reg_cl_i;
        end else begin
            alloc_preg_d = ring_q[head_d[IDX_W-1:0]];
        end
    end

    // Pointer and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q        <= {PTR_W{1'b0}};
            commit_head_q <= {PTR_W{1'b0}};
            tail_q        <= PTR_W'(NUM_FREE);
            alloc_v_q     <= (NUM_FREE != 0);
            alloc_preg_q  <= preg_id_t'(NUM_ARCH_REG);
            free_count_q  <= PTR_W'(NUM_FREE);
        end else begin
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            alloc_v_q     <= alloc_v_d;
            alloc_preg_q  <= alloc_preg_d;
            free_count_q  <= free_count_d;
        end
    end

    // Ring storage: reset image holds every non-architectural preg in ascending order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                ring_q[i] <= (i < NUM_FREE) ? preg_id_t'(NUM_ARCH_REG + i) : preg_id_t'(0);
            end
        end else if (rob_phys_valid_i) begin
            ring_q[tail_q[IDX_W-1:0]] <= rob_phys_reg_cl_i;
        end else begin
            ring_q <= ring_q;
        end
    end

    assign alloc_v_o    = alloc_v_q;
    assign alloc_preg_o = alloc_preg_q;
    assign free_count_o = free_count_q;

`ifndef SYNTHESIS
    logic [PTR_W-1:0] occupancy_s;
    assign occupancy_s = tail_q - commit_head_q;

    a_free_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        rob_phys_valid_i |-> (occupancy_s != PTR_W'(FL_DEPTH)));
    a_yumi_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        alloc_yumi_i |-> alloc_v_q);
    a_commit_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        rob_commit_alloc_i |-> (commit_head_q != head_q));
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench: stimulus pushes expected status/IDs, a negedge monitor pops and compares.
module tb_phys_reg_free_list;
    import Purple_Jade_pkg::*;

    localparam int PW = $clog2(NUM_PHYS_REG) + 1;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           alloc_v_o;
    preg_id_t       alloc_preg_o;
    logic           alloc_yumi_i = 1'b0;
    logic           rob_phys_valid_i = 1'b0;
    preg_id_t       rob_phys_reg_cl_i = '0;
    logic           rob_commit_alloc_i = 1'b0;
    logic           flush_i = 1'b0;
    logic [PW-1:0]  free_count_o;

    always #5 clk = ~clk;

    phys_reg_free_list #(.FL_DEPTH(NUM_PHYS_REG)) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .alloc_v_o          (alloc_v_o),
        .alloc_preg_o       (alloc_preg_o),
        .alloc_yumi_i       (alloc_yumi_i),
        .rob_phys_valid_i   (rob_phys_valid_i),
        .rob_phys_reg_cl_i  (rob_phys_reg_cl_i),
        .rob_commit_alloc_i (rob_commit_alloc_i),
        .flush_i            (flush_i),
        .free_count_o       (free_count_o)
    );

    typedef struct packed {
        logic          v;
        logic          chk_p;
        preg_id_t      p;
        logic [PW-1:0] cnt;
    } stat_t;

    stat_t    stat_q[$];
    preg_id_t id_q[$];
    int       n_tests = 0;
    int       n_fail  = 0;
    logic     end_chk = 1'b0;

    // Spec-level model for the random phase: committed-head..tail contents and speculative depth.
    preg_id_t mfl[$];
    preg_id_t live[$];
    int       nspec;

    // Monitor-side ownership shadow built only from what the DUT hands out.
    logic     held [NUM_PHYS_REG];
    preg_id_t spec_ids[$];

    task automatic reset_model();
        mfl.delete();
        live.delete();
        for (int i = NUM_ARCH_REG; i < NUM_PHYS_REG; i++) mfl.push_back(preg_id_t'(i));
        for (int i = 0; i < NUM_ARCH_REG; i++) live.push_back(preg_id_t'(i));
        nspec = 0;
    endtask

    // One cycle of stimulus plus the expected outputs visible during that cycle.
    task automatic cyc(input logic y, input logic fv, input int fid, input logic cm,
                       input logic fls, input logic rs,
                       input logic ev, input logic ecp, input int ep, input int ecnt);
        stat_t s;
        @(posedge clk);
        #1;
        alloc_yumi_i       = y;
        rob_phys_valid_i   = fv;
        rob_phys_reg_cl_i  = preg_id_t'(fid);
        rob_commit_alloc_i = cm;
        flush_i            = fls;
        reset_i            = rs;
        if (!rs) begin
            s.v     = ev;
            s.chk_p = ecp;
            s.p     = preg_id_t'(ep);
            s.cnt   = PW'(ecnt);
            stat_q.push_back(s);
            if (y && !fls) id_q.push_back(preg_id_t'(ep));
        end
    endtask

    always @(negedge clk) begin
        stat_t    s;
        preg_id_t e;
        if (end_chk) begin
            n_tests++;
            if (stat_q.size() != 0 || id_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: stat=%0d id=%0d pending, required 0/0", stat_q.size(), id_q.size());
            end
        end else if (reset_i) begin
            for (int i = 0; i < NUM_PHYS_REG; i++) held[i] = (i < NUM_ARCH_REG);
            spec_ids.delete();
        end else begin
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                n_tests++;
                if (alloc_v_o !== s.v || free_count_o !== s.cnt || (s.chk_p && alloc_preg_o !== s.p)) begin
                    n_fail++;
                    $display("FAIL status t=%0t: v=%0b preg=%0d cnt=%0d, required v=%0b preg=%0d cnt=%0d",
                             $time, alloc_v_o, alloc_preg_o, free_count_o, s.v, s.p, s.cnt);
                end
            end
            if (rob_commit_alloc_i && spec_ids.size() > 0) void'(spec_ids.pop_front());
            if (alloc_v_o && alloc_yumi_i && !flush_i) begin
                n_tests++;
                if (id_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL alloc_id t=%0t: got %0d, required no allocation", $time, alloc_preg_o);
                end else begin
                    e = id_q.pop_front();
                    if (alloc_preg_o !== e) begin
                        n_fail++;
                        $display("FAIL alloc_id t=%0t: got %0d, required %0d", $time, alloc_preg_o, e);
                    end
                end
                n_tests++;
                if (held[alloc_preg_o]) begin
                    n_fail++;
                    $display("FAIL dup t=%0t: preg %0d handed out while owned, required unowned", $time, alloc_preg_o);
                end
                held[alloc_preg_o] = 1'b1;
                spec_ids.push_back(alloc_preg_o);
            end
            if (flush_i) begin
                foreach (spec_ids[k]) held[spec_ids[k]] = 1'b0;
                spec_ids.delete();
            end
            if (rob_phys_valid_i) held[rob_phys_reg_cl_i] = 1'b0;
        end
    end

    initial begin
        logic mv, y, fv, cm, fls, rs;
        int   ep, fid, k;

        // Reset, then drain all 112 free IDs in order.
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < NUM_PHYS_REG - NUM_ARCH_REG; i++)
            cyc(1, 0, 0, 0, 0, 0, 1, 1, NUM_ARCH_REG + i, NUM_PHYS_REG - NUM_ARCH_REG - i);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Free into an empty list: visible only a cycle later.
        cyc(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 5, 1);

        // Allocate 16,17,18, commit one, flush back to 17.
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 16, 112);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 17, 111);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 18, 110);
        cyc(0, 0, 0, 1, 0, 0, 1, 1, 19, 109);
        cyc(0, 0, 0, 0, 1, 0, 1, 1, 19, 109);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 17, 111);

        // head=2, commit_head=1, then yumi+free+commit+flush together.
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 16, 112);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 17, 111);
        cyc(0, 0, 0, 1, 0, 0, 1, 1, 18, 110);
        cyc(1, 1, 3, 1, 1, 0, 1, 1, 18, 110);
        cyc(0, 0, 0, 0, 1, 0, 1, 1, 18, 111);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 18, 111);

        // Random mix with a mid-run reset.
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        reset_model();
        for (int c = 0; c < 10000; c++) begin
            mv  = (nspec < mfl.size());
            ep  = mv ? int'(mfl[nspec]) : 0;
            y   = mv && ($urandom_range(3) != 0);
            cm  = (nspec > 0) && ($urandom_range(2) == 0);
            fv  = (live.size() > 0) && ($urandom_range(2) == 0);
            fid = 0;
            if (fv) begin
                k   = $urandom_range(live.size() - 1);
                fid = int'(live[k]);
                live.delete(k);
            end
            fls = ($urandom_range(31) == 0);
            rs  = (c == 5000);
            cyc(y, fv, fid, cm, fls, rs, mv, mv, ep, mfl.size() - nspec);
            if (rs) begin
                reset_model();
            end else begin
                if (cm) begin
                    live.push_back(mfl.pop_front());
                    nspec--;
                end
                if (y && !fls) nspec++;
                if (fls) nspec = 0;
                if (fv) mfl.push_back(preg_id_t'(fid));
            end
        end

        @(posedge clk);
        #1;
        alloc_yumi_i       = 1'b0;
        rob_phys_valid_i   = 1'b0;
        rob_commit_alloc_i = 1'b0;
        flush_i            = 1'b0;
        end_chk            = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Allocator for the physical register file. It holds the IDs of unallocated physical registers in a circular list. It hands one ID per cycle to rename and takes back one ID per cycle from the ROB commit stage. On a pipeline flush it rolls speculative allocations back to the last committed point. It sits between rename, the ROB and the physical register file, and is the only arbiter of physical register ownership.

## Interface
- NUM_PHYS_REG, 128, physical registers; from shared package
- NUM_ARCH_REG, 16, architectural registers; pregs 0..NUM_ARCH_REG-1 are the reset architectural mapping
- FL_DEPTH, NUM_PHYS_REG, ring entries; power of two
- clk_i  in  1  clock
- reset_i  in  1  reset; synchronous, active-high
- alloc_v_o  out  1  a free preg is available at the head
- alloc_preg_o  out  $clog2(NUM_PHYS_REG)  preg ID at the head
- alloc_yumi_i  in  1  rename consumes alloc_preg_o this cycle; legal only when alloc_v_o=1
- rob_phys_valid_i  in  1  commit frees a preg (the old mapping of the committed destination)
- rob_phys_reg_cl_i  in  $clog2(NUM_PHYS_REG)  preg ID being freed
- rob_commit_alloc_i  in  1  committing instruction owned an allocated destination preg
- flush_i  in  1  discard all uncommitted allocations
- free_count_o  out  $clog2(FL_DEPTH)+1  speculative free count (tail − head)

## Operation
- State:
  - ring[FL_DEPTH] of preg IDs.
  - Pointers head (speculative allocation), commit_head and tail.
  - Each pointer is $clog2(FL_DEPTH)+1 bits; the MSB is the wrap bit, the index is the low bits.
- Reset:
  - ring[i] = NUM_ARCH_REG+i for i < NUM_PHYS_REG−NUM_ARCH_REG.
  - head = commit_head = 0.
  - tail = NUM_PHYS_REG−NUM_ARCH_REG (112).
  - Outputs: alloc_v_o=1, alloc_preg_o=16, free_count_o=112.
- Allocate: when alloc_v_o && alloc_yumi_i && !flush_i, head += 1.
- Free: when rob_phys_valid_i, write ring[tail]=rob_phys_reg_cl_i and set tail += 1. This happens regardless of flush_i.
- Commit: when rob_commit_alloc_i, commit_head += 1.
- Flush:
  - head_n = commit_head_n, i.e. commit_head after applying this cycle's commit.
  - A yumi in the same cycle is ignored.
  - Entries between commit_head and head are never overwritten, so they become allocatable again with no copy.
- alloc_v_o = (head != tail). Compare the full pointers including the wrap bit.
- free_count_o = tail − head, modulo 2^(ptr width).
- Invariant: tail − commit_head ≤ FL_DEPTH.
  - Free while (tail − commit_head) == FL_DEPTH is illegal; assert it.
  - yumi while !alloc_v_o is illegal; assert it, and leave the state unchanged.
  - commit while commit_head == head is illegal; assert it.
- No double-free detection in RTL. The bench checks it with a shadow bitmap.

## Timing
- alloc_v_o, alloc_preg_o and free_count_o come from flops only. There is no combinational path from any input.
- A freed preg is allocatable at the earliest one cycle after rob_phys_valid_i. There is no same-cycle bypass when the list is empty.
- Allocation latency is 0: the ID is valid in the cycle alloc_v_o is high, and the next ID appears the cycle after yumi.
- After flush_i, alloc_preg_o = ring[commit_head_n] in the following cycle.
- Alloc, free and commit in the same cycle are all applied. Flush overrides only the head update.
- Reset mid-operation restores the full reset image next cycle, regardless of other inputs.
- Pointer wrap: the index wraps from FL_DEPTH−1 to 0 and the wrap bit toggles; full and empty are distinguished by the wrap bit.

## Structure
- NUM_PHYS_REG, NUM_ARCH_REG and a preg_id_t typedef go in Purple_Jade_pkg.
- The NUM_ARCH_REG value must stay consistent with the register-file valid reset image.
- Single module. No sub-module; the ring and pointer logic are too small to split.
- Assertions sit in a non-synthesized block inside the module.

## Test plan
- Reset, then yumi for 112 consecutive cycles -> IDs 16..127 in order; alloc_v_o=0 and free_count_o=0 afterwards.
- From empty, free preg 5 -> alloc_v_o=0 in the same cycle; alloc_v_o=1 and alloc_preg_o=5 next cycle.
- Allocate 16,17,18, commit one, then flush -> next cycle alloc_preg_o=17 and free_count_o=111.
- Same cycle: yumi, free preg 3, commit, flush with prior state head=2, commit_head=1 -> head=2, commit_head=2, tail+1; the yumi is dropped.
- Run a random alloc/free/commit/flush mix for 10k cycles with wrap -> no ID duplicated across free list plus allocated set, and free_count_o matches the model.
- Assert reset in the middle of the random run -> next cycle outputs equal the reset values (1, 16, 112).
